// File: rtl/jtcop_mcu_bridge_if.sv
// Signal bundle between the main CPU bus, the i8751 port bus and the mailbox bridge.
// The bridge takes the slave view; the CPU/MCU side (or a bench) takes the master view.
interface jtcop_mcu_bridge_if #(
    parameter int CHW = 2
);
    logic           main_cs;
    logic           main_rnw;
    logic [CHW-1:0] main_ch;
    logic [1:0]     main_dsn;
    logic [15:0]    main_din;
    logic [15:0]    main_dout;
    logic           main_ok;
    logic [1:0]     mcu_rd_sel;
    logic           mcu_pop;
    logic [CHW-1:0] mcu_wr_ch;
    logic           mcu_wr_lo;
    logic           mcu_wr_hi;
    logic [7:0]     mcu_p0o;
    logic [7:0]     mcu_p0i;
    logic           mcu_int_ack;
    logic           mcu_intn;

    modport master (
        output main_cs, main_rnw, main_ch, main_dsn, main_din,
        output mcu_rd_sel, mcu_pop, mcu_wr_ch, mcu_wr_lo, mcu_wr_hi, mcu_p0o, mcu_int_ack,
        input  main_dout, main_ok, mcu_p0i, mcu_intn
    );

    modport slave (
        input  main_cs, main_rnw, main_ch, main_dsn, main_din,
        input  mcu_rd_sel, mcu_pop, mcu_wr_ch, mcu_wr_lo, mcu_wr_hi, mcu_p0o, mcu_int_ack,
        output main_dout, main_ok, mcu_p0i, mcu_intn
    );
endinterface

// File: rtl/jtcop_mcu_bridge.sv
// Mailbox bridge: main CPU writes queue into a command FIFO drained bytewise by the
// i8751 through P0; the MCU answers through per-channel 16-bit reply registers.
module jtcop_mcu_bridge #(
    parameter int CHW      = 2,
    parameter int AW       = 2,
    parameter int IRQ_EDGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    jtcop_mcu_bridge_if.slave bus
);
    localparam int CH    = 1 << CHW;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = CHW + 16;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [CH-1:0][15:0]      reply_q, reply_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     wr_term_q, wr_term_d;
    logic                     rd_term_q, rd_term_d;
    logic [1:0]               rd_sel_q, rd_sel_d;
    logic [7:0]               p0i_q, p0i_d;
    logic                     intn_q, intn_d;
    logic [15:0]              dout_q, dout_d;
    logic                     ok_q, ok_d;

    logic          push, push_ok, pop_ok, empty, full, status_rd, rd_edge;
    logic [15:0]   wdata;
    logic [EW-1:0] head;
    logic [7:0]    status;

    always_comb begin
        wr_term_d = bus.main_cs & ~bus.main_rnw;
        rd_term_d = bus.main_cs &  bus.main_rnw;
        push      = wr_term_d & ~wr_term_q;
        rd_edge   = rd_term_d & ~rd_term_q;
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        pop_ok    = bus.mcu_pop & ~empty;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        push_ok   = push & (~full | pop_ok);
        wdata     = {bus.main_dsn[1] ? 8'h00 : bus.main_din[15:8],
                     bus.main_dsn[0] ? 8'h00 : bus.main_din[7:0]};
        head      = mem_q[rd_ptr_q];
        status    = {empty, full, ovf_q, 5'(count_q)};
        status_rd = (bus.mcu_rd_sel == 2'd2) && (rd_sel_q != 2'd2);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {bus.main_ch, wdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_comb begin
        // A fresh overflow outranks a status-read clear so it is never lost.
        ovf_d = ovf_q;
        if (status_rd)
            ovf_d = 1'b0;
        if (push & ~push_ok)
            ovf_d = 1'b1;
    end

    always_comb begin
        rd_sel_d = bus.mcu_rd_sel;
        case (bus.mcu_rd_sel)
            2'd0:    p0i_d = head[7:0];
            2'd1:    p0i_d = head[15:8];
            2'd2:    p0i_d = status;
            default: p0i_d = 8'(head[EW-1:16]);
        endcase
    end

    always_comb begin
        if (IRQ_EDGE != 0) begin
            intn_d = intn_q;
            if (bus.mcu_int_ack)
                intn_d = 1'b1;
            if (push_ok)
                intn_d = 1'b0;
        end else begin
            intn_d = (count_d == '0);
        end
    end

    always_comb begin
        reply_d = reply_q;
        if (bus.mcu_wr_lo)
            reply_d[bus.mcu_wr_ch][7:0] = bus.mcu_p0o;
        if (bus.mcu_wr_hi)
            reply_d[bus.mcu_wr_ch][15:8] = bus.mcu_p0o;
        // Reads sample the registered reply, so a same-cycle MCU write shows up next time.
        dout_d = rd_edge ? reply_q[bus.main_ch] : dout_q;
        ok_d   = rd_term_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q     <= '0;
            reply_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            wr_term_q <= 1'b0;
            rd_term_q <= 1'b0;
            rd_sel_q  <= 2'd0;
            p0i_q     <= 8'h00;
            intn_q    <= 1'b1;
            dout_q    <= 16'h0000;
            ok_q      <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            reply_q   <= reply_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wr_term_q <= wr_term_d;
            rd_term_q <= rd_term_d;
            rd_sel_q  <= rd_sel_d;
            p0i_q     <= p0i_d;
            intn_q    <= intn_d;
            dout_q    <= dout_d;
            ok_q      <= ok_d;
        end
    end

    assign bus.mcu_p0i   = p0i_q;
    assign bus.mcu_intn  = intn_q;
    assign bus.main_dout = dout_q;
    assign bus.main_ok   = ok_q;
endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Bench for the MCU mailbox bridge: a level-IRQ instance checked against a FIFO/reply
// model plus an edge-IRQ instance for the latched interrupt behaviour.
module tb_jtcop_mcu_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtcop_mcu_bridge_if #(.CHW(2)) bl ();
    jtcop_mcu_bridge_if #(.CHW(2)) be ();

    jtcop_mcu_bridge #(.CHW(2), .AW(2), .IRQ_EDGE(0)) u_lvl (.clk(clk), .rst_n(rst_n), .bus(bl.slave));
    jtcop_mcu_bridge #(.CHW(2), .AW(2), .IRQ_EDGE(1)) u_edg (.clk(clk), .rst_n(rst_n), .bus(be.slave));

    int n_pass = 0;
    int n_total = 0;
    logic [17:0] exp_q[$];
    logic        ovf_m = 1'b0;
    logic [15:0] rep_m [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bl.main_cs = 0; bl.main_rnw = 0; bl.main_ch = 0; bl.main_dsn = 2'b11; bl.main_din = 0;
        bl.mcu_rd_sel = 0; bl.mcu_pop = 0; bl.mcu_wr_ch = 0; bl.mcu_wr_lo = 0; bl.mcu_wr_hi = 0;
        bl.mcu_p0o = 0; bl.mcu_int_ack = 0;
        be.main_cs = 0; be.main_rnw = 0; be.main_ch = 0; be.main_dsn = 2'b11; be.main_din = 0;
        be.mcu_rd_sel = 0; be.mcu_pop = 0; be.mcu_wr_ch = 0; be.mcu_wr_lo = 0; be.mcu_wr_hi = 0;
        be.mcu_p0o = 0; be.mcu_int_ack = 0;
    endtask

    // Drives one main-CPU write held for `hold` cycles, optionally with an MCU pop on the
    // edge cycle, and updates the FIFO model accordingly.
    task automatic main_write(input logic [1:0] ch, input logic [1:0] dsn, input logic [15:0] din,
                              input int hold, input logic pop_also);
        logic [15:0] m;
        m = {dsn[1] ? 8'h00 : din[15:8], dsn[0] ? 8'h00 : din[7:0]};
        if (pop_also && exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_q.size() < 4) exp_q.push_back({ch, m});
        else ovf_m = 1'b1;
        bl.main_cs = 1; bl.main_rnw = 0; bl.main_ch = ch; bl.main_dsn = dsn; bl.main_din = din;
        bl.mcu_pop = pop_also;
        tick();
        bl.mcu_pop = 0;
        for (int i = 1; i < hold; i++) tick();
        bl.main_cs = 0; bl.main_dsn = 2'b11;
        tick();
    endtask

    task automatic check_status(input string name);
        logic [7:0] e;
        e = {exp_q.size() == 0, exp_q.size() == 4, ovf_m, 5'(exp_q.size())};
        bl.mcu_rd_sel = 0;
        tick();
        bl.mcu_rd_sel = 2;
        tick();
        n_total++;
        if (bl.mcu_p0i !== e) $display("FAIL %s status: got %h want %h", name, bl.mcu_p0i, e);
        else n_pass++;
        ovf_m = 1'b0;
        bl.mcu_rd_sel = 0;
    endtask

    // Scoreboard drain: compares all three head views against the model front, then pops.
    task automatic check_head(input string name);
        logic [17:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s head: got scoreboard empty want entry", name);
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        bl.mcu_rd_sel = 0;
        tick();
        n_total++;
        if (bl.mcu_p0i !== e[7:0]) $display("FAIL %s lo: got %h want %h", name, bl.mcu_p0i, e[7:0]);
        else n_pass++;
        bl.mcu_rd_sel = 1;
        tick();
        n_total++;
        if (bl.mcu_p0i !== e[15:8]) $display("FAIL %s hi: got %h want %h", name, bl.mcu_p0i, e[15:8]);
        else n_pass++;
        bl.mcu_rd_sel = 3;
        tick();
        n_total++;
        if (bl.mcu_p0i !== {6'b0, e[17:16]}) $display("FAIL %s ch: got %h want %h", name, bl.mcu_p0i, {6'b0, e[17:16]});
        else n_pass++;
        bl.mcu_rd_sel = 0;
        bl.mcu_pop = 1;
        tick();
        bl.mcu_pop = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        n_total++;
        if ({bl.mcu_intn, bl.mcu_p0i, bl.main_dout, bl.main_ok, be.mcu_intn} !== {1'b1, 8'h00, 16'h0000, 1'b0, 1'b1})
            $display("FAIL reset: got intn=%b p0i=%h dout=%h ok=%b eintn=%b want 1/00/0000/0/1",
                     bl.mcu_intn, bl.mcu_p0i, bl.main_dout, bl.main_ok, be.mcu_intn);
        else n_pass++;
        rst_n = 1;
        tick();
        check_status("reset");
    endtask

    task automatic test_push_basic();
        main_write(2'd1, 2'b00, 16'hA55A, 1, 1'b0);
        n_total++;
        if (bl.mcu_p0i !== 8'h5A) $display("FAIL push_latency: got %h want 5a", bl.mcu_p0i);
        else n_pass++;
        check_status("push_basic");
        n_total++;
        if (bl.mcu_intn !== 1'b0) $display("FAIL push_intn: got %b want 0", bl.mcu_intn);
        else n_pass++;
        check_head("push_basic");
        check_status("push_drained");
        n_total++;
        if (bl.mcu_intn !== 1'b1) $display("FAIL drain_intn: got %b want 1", bl.mcu_intn);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            main_write(2'(i), 2'b00, 16'($urandom), 1, 1'b0);
        check_status("ovf_set");
        check_status("ovf_cleared");
        for (int i = 0; i < 4; i++) check_head("ovf_drain");
        check_status("ovf_empty");
        n_total++;
        if (bl.mcu_intn !== 1'b1) $display("FAIL ovf_intn: got %b want 1", bl.mcu_intn);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++)
            main_write(2'(3 - i), 2'b00, 16'h1100 + 16'(i), 1, 1'b0);
        main_write(2'd2, 2'b00, 16'hF00D, 1, 1'b1);
        check_status("full_push_pop");
        for (int i = 0; i < 4; i++) check_head("full_pop_drain");
        bl.mcu_pop = 1;
        tick();
        bl.mcu_pop = 0;
        check_status("pop_empty");
        main_write(2'd3, 2'b00, 16'h0BAD, 1, 1'b1);
        check_status("empty_push_pop");
        check_head("empty_push_pop");
    endtask

    task automatic test_strobe();
        main_write(2'd0, 2'b10, 16'h1234, 1, 1'b0);
        main_write(2'd1, 2'b01, 16'h1234, 1, 1'b0);
        check_head("dsn10");
        check_head("dsn01");
    endtask

    task automatic test_reply();
        bl.mcu_wr_ch = 2; bl.mcu_p0o = 8'hCD; bl.mcu_wr_lo = 1;
        tick();
        bl.mcu_wr_lo = 0; bl.mcu_p0o = 8'hAB; bl.mcu_wr_hi = 1;
        tick();
        bl.mcu_wr_hi = 0;
        rep_m[2] = 16'hABCD;
        bl.mcu_wr_ch = 3; bl.mcu_p0o = 8'h77; bl.mcu_wr_lo = 1; bl.mcu_wr_hi = 1;
        tick();
        bl.mcu_wr_lo = 0; bl.mcu_wr_hi = 0;
        rep_m[3] = 16'h7777;
        bl.main_cs = 1; bl.main_rnw = 1; bl.main_ch = 2;
        tick();
        n_total++;
        if ({bl.main_ok, bl.main_dout} !== {1'b1, rep_m[2]})
            $display("FAIL read_ch2: got ok=%b dout=%h want 1/%h", bl.main_ok, bl.main_dout, rep_m[2]);
        else n_pass++;
        tick();
        n_total++;
        if (bl.main_ok !== 1'b1) $display("FAIL ok_held: got %b want 1", bl.main_ok);
        else n_pass++;
        bl.main_cs = 0;
        tick();
        n_total++;
        if (bl.main_ok !== 1'b0) $display("FAIL ok_drop: got %b want 0", bl.main_ok);
        else n_pass++;
        bl.main_cs = 1; bl.main_ch = 3;
        bl.mcu_wr_ch = 3; bl.mcu_p0o = 8'h11; bl.mcu_wr_lo = 1;
        tick();
        bl.mcu_wr_lo = 0;
        n_total++;
        if (bl.main_dout !== rep_m[3]) $display("FAIL read_collide: got %h want %h", bl.main_dout, rep_m[3]);
        else n_pass++;
        rep_m[3][7:0] = 8'h11;
        bl.main_cs = 0;
        tick();
        bl.main_cs = 1;
        tick();
        n_total++;
        if (bl.main_dout !== rep_m[3]) $display("FAIL read_after: got %h want %h", bl.main_dout, rep_m[3]);
        else n_pass++;
        bl.main_cs = 0; bl.main_rnw = 0;
        tick();
    endtask

    task automatic test_irq_edge();
        be.main_cs = 1; be.main_rnw = 0; be.main_dsn = 2'b00; be.main_din = 16'h5555;
        tick();
        be.main_cs = 0;
        n_total++;
        if (be.mcu_intn !== 1'b0) $display("FAIL edge_push: got %b want 0", be.mcu_intn);
        else n_pass++;
        be.mcu_int_ack = 1;
        tick();
        be.mcu_int_ack = 0;
        n_total++;
        if (be.mcu_intn !== 1'b1) $display("FAIL edge_ack: got %b want 1", be.mcu_intn);
        else n_pass++;
        be.main_cs = 1; be.mcu_int_ack = 1;
        tick();
        be.main_cs = 0; be.mcu_int_ack = 0;
        tick();
        n_total++;
        if (be.mcu_intn !== 1'b0) $display("FAIL edge_ack_push: got %b want 0", be.mcu_intn);
        else n_pass++;
    endtask

    task automatic test_hold();
        main_write(2'd0, 2'b00, 16'hBEEF, 10, 1'b0);
        check_status("hold_one_push");
        check_head("hold");
    endtask

    task automatic test_reset_mid();
        main_write(2'd1, 2'b00, 16'h0101, 1, 1'b0);
        main_write(2'd2, 2'b00, 16'h0202, 1, 1'b0);
        bl.main_cs = 1; bl.main_rnw = 1; bl.main_ch = 2;
        bl.mcu_rd_sel = 1;
        tick();
        rst_n = 0;
        tick();
        n_total++;
        if ({bl.mcu_intn, bl.mcu_p0i, bl.main_dout, bl.main_ok, be.mcu_intn} !== {1'b1, 8'h00, 16'h0000, 1'b0, 1'b1})
            $display("FAIL reset_mid: got intn=%b p0i=%h dout=%h ok=%b eintn=%b want 1/00/0000/0/1",
                     bl.mcu_intn, bl.mcu_p0i, bl.main_dout, bl.main_ok, be.mcu_intn);
        else n_pass++;
        exp_q.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 4; i++) rep_m[i] = 16'h0000;
        bl.main_cs = 0; bl.main_rnw = 0; bl.mcu_rd_sel = 0;
        rst_n = 1;
        tick();
        check_status("reset_mid");
        bl.main_cs = 1; bl.main_rnw = 1; bl.main_ch = 2;
        tick();
        n_total++;
        if (bl.main_dout !== rep_m[2]) $display("FAIL reset_reply: got %h want %h", bl.main_dout, rep_m[2]);
        else n_pass++;
        bl.main_cs = 0; bl.main_rnw = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rep_m[i] = 16'h0000;
        test_reset();
        test_push_basic();
        test_overflow();
        test_full_pop();
        test_strobe();
        test_reply();
        test_irq_edge();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
